// File: rtl/hero_write_arb_if.sv
// Hero write bus bundle: per-channel producer inputs, merged consumer output,
// sticky error flags and their clear pulse.
interface hero_write_arb_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 36,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
);
  logic [2*NUM_CH-1:0]      in_cycle_type;
  logic [DATA_W*NUM_CH-1:0] in_wdat;
  logic [NUM_CH-1:0]        in_clk_en;
  logic                     out_ready;
  logic [1:0]               out_cycle_type;
  logic [DATA_W-1:0]        out_wdat;
  logic [CH_W-1:0]          out_ch;
  logic [NUM_CH-1:0]        ovf;
  logic [NUM_CH-1:0]        proto_err;
  logic                     err_clr;

  // Producer/consumer side (testbench or surrounding logic)
  modport master (
    output in_cycle_type, in_wdat, in_clk_en, out_ready, err_clr,
    input  out_cycle_type, out_wdat, out_ch, ovf, proto_err
  );

  // Arbiter side
  modport slave (
    input  in_cycle_type, in_wdat, in_clk_en, out_ready, err_clr,
    output out_cycle_type, out_wdat, out_ch, ovf, proto_err
  );
endinterface

// File: rtl/hero_write_arb.sv
// Multi-channel hero write arbiter: one FIFO per producer, round-robin
// selection with a transaction lock so VALID..DONE runs are never interleaved.
module hero_write_arb #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 36,
  parameter int unsigned DEPTH  = 8
) (
  input logic             clk,
  input logic             rst_n,
  hero_write_arb_if.slave bus
);
  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned BW   = DATA_W + 2;

  localparam logic [1:0] CtIdle  = 2'd0;
  localparam logic [1:0] CtValid = 2'd1;
  localparam logic [1:0] CtDone  = 2'd2;
  localparam logic [1:0] CtBad   = 2'd3;

  typedef enum logic [0:0] {StArb, StLock} state_e;

  // Per-channel FIFO state
  logic [BW-1:0]     r_mem  [NUM_CH][DEPTH];
  logic [AW-1:0]     r_wptr [NUM_CH];
  logic [AW-1:0]     r_rptr [NUM_CH];
  logic [CW-1:0]     r_cnt  [NUM_CH];
  logic [NUM_CH-1:0] r_ovf;
  logic [NUM_CH-1:0] r_proto_err;

  // Arbiter state
  state_e          r_state;
  logic [CH_W-1:0] r_lock_ch;
  logic [CH_W-1:0] r_rr_ptr;

  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_ovf_set;
  logic [NUM_CH-1:0] w_proto_set;
  logic [CH_W-1:0]   w_scan_ch;
  logic              w_scan_hit;
  logic [CH_W-1:0]   w_sel_ch;
  logic              w_valid;
  logic              w_xfer;
  logic [BW-1:0]     w_head;
  logic [1:0]        w_head_type;

  // (base + off) mod NUM_CH, with off < NUM_CH
  function automatic logic [CH_W-1:0] f_wrap(input logic [CH_W-1:0] base,
                                             input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return s[CH_W-1:0];
  endfunction

  // Occupancy status, purely from registered counts
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_empty[c] = (r_cnt[c] == '0);
      w_full[c]  = (r_cnt[c] == CW'(DEPTH));
    end
  end

  // Round-robin scan: first non-empty channel at or after rr_ptr
  always_comb begin
    w_scan_ch  = '0;
    w_scan_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!w_scan_hit && !w_empty[f_wrap(r_rr_ptr, i)]) begin
        w_scan_hit = 1'b1;
        w_scan_ch  = f_wrap(r_rr_ptr, i);
      end
    end
  end

  // Output selection; a locked channel blocks everyone else, even when empty
  always_comb begin
    w_sel_ch    = (r_state == StLock) ? r_lock_ch : w_scan_ch;
    w_valid     = (r_state == StLock) ? !w_empty[r_lock_ch] : w_scan_hit;
    w_head      = r_mem[w_sel_ch][r_rptr[w_sel_ch]];
    w_head_type = w_head[BW-1 -: 2];
    w_xfer      = w_valid && bus.out_ready;
  end

  assign bus.out_cycle_type = w_valid ? w_head_type : CtIdle;
  assign bus.out_wdat       = w_valid ? w_head[DATA_W-1:0] : '0;
  assign bus.out_ch         = w_valid ? w_sel_ch : '0;
  assign bus.ovf            = r_ovf;
  assign bus.proto_err      = r_proto_err;

  // Push/pop decode; a full FIFO still accepts a push when it pops this cycle
  always_comb begin
    w_push      = '0;
    w_pop       = '0;
    w_ovf_set   = '0;
    w_proto_set = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      logic [1:0] ct;
      logic       req;
      ct             = bus.in_cycle_type[2*c +: 2];
      req            = bus.in_clk_en[c] && (ct == CtValid || ct == CtDone);
      w_pop[c]       = w_xfer && (w_sel_ch == CH_W'(c));
      w_push[c]      = req && (!w_full[c] || w_pop[c]);
      w_ovf_set[c]   = req && w_full[c] && !w_pop[c];
      w_proto_set[c] = bus.in_clk_en[c] && (ct == CtBad);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) r_wptr[c] <= r_wptr[c] + AW'(1);
        if (w_pop[c])  r_rptr[c] <= r_rptr[c] + AW'(1);
        if (w_push[c] && !w_pop[c])      r_cnt[c] <= r_cnt[c] + CW'(1);
        else if (!w_push[c] && w_pop[c]) r_cnt[c] <= r_cnt[c] - CW'(1);
      end
    end
  end

  // FIFO storage; occupancy gates every read so no reset is needed
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_push[c]) begin
        r_mem[c][r_wptr[c]] <= {bus.in_cycle_type[2*c +: 2], bus.in_wdat[DATA_W*c +: DATA_W]};
      end
    end
  end

  // Sticky error flags; a new set beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf       <= '0;
      r_proto_err <= '0;
    end else begin
      r_ovf       <= (r_ovf & ~{NUM_CH{bus.err_clr}}) | w_ovf_set;
      r_proto_err <= (r_proto_err & ~{NUM_CH{bus.err_clr}}) | w_proto_set;
    end
  end

  // Arbiter FSM. A stalled ARB beat parks rr_ptr on its channel so the next
  // scan lands on the same head; the channels it skipped were empty anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StArb;
      r_lock_ch <= '0;
      r_rr_ptr  <= '0;
    end else begin
      case (r_state)
        StArb: begin
          if (w_xfer) begin
            if (w_head_type == CtValid) begin
              r_state   <= StLock;
              r_lock_ch <= w_sel_ch;
            end else begin
              r_rr_ptr <= f_wrap(w_sel_ch, 1);
            end
          end else if (w_valid) begin
            r_rr_ptr <= w_sel_ch;
          end
        end
        StLock: begin
          if (w_xfer && w_head_type == CtDone) begin
            r_state  <= StArb;
            r_rr_ptr <= f_wrap(r_lock_ch, 1);
          end
        end
        default: r_state <= StArb;
      endcase
    end
  end
endmodule

// File: tb/tb_hero_write_arb.sv
// Directed bench for hero_write_arb with a per-channel scoreboard checking
// every transferred beat, transaction locking and output stability.
module tb_hero_write_arb;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 36;
  localparam int unsigned DEPTH  = 8;

  localparam logic [1:0] CtIdle  = 2'd0;
  localparam logic [1:0] CtValid = 2'd1;
  localparam logic [1:0] CtDone  = 2'd2;
  localparam logic [1:0] CtBad   = 2'd3;

  typedef logic [DATA_W+1:0] beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hero_write_arb_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  hero_write_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_checks = 0;
  int    n_errs   = 0;
  beat_t sb_q [NUM_CH][$];
  logic  stall_q = 1'b0;
  beat_t stall_beat;
  logic [1:0] stall_ch;
  logic  mon_lock = 1'b0;
  logic [1:0] mon_lock_ch;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] t, input logic [35:0] d,
                           input logic [1:0] ch);
    check(tag, 64'({bus.out_cycle_type, bus.out_wdat, bus.out_ch}), 64'({t, d, ch}));
  endtask

  task automatic drive(input int ch, input logic [1:0] t, input logic [35:0] d, input bit keep);
    bus.in_cycle_type[2*ch +: 2] = t;
    bus.in_wdat[DATA_W*ch +: DATA_W] = d;
    bus.in_clk_en[ch] = 1'b1;
    if (keep) sb_q[ch].push_back({t, d});
  endtask

  function automatic bit sb_all_empty();
    for (int c = 0; c < NUM_CH; c++) if (sb_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Called on the falling edge: decides what the coming rising edge transfers
  task automatic mon();
    beat_t cur;
    cur = {bus.out_cycle_type, bus.out_wdat};
    if (stall_q) check("stable", 64'({cur, bus.out_ch}), 64'({stall_beat, stall_ch}));
    stall_q = 1'b0;
    if (bus.out_cycle_type == CtIdle) begin
      check("idle_zero", 64'({bus.out_wdat, bus.out_ch}), 64'h0);
    end else if (bus.out_ready) begin
      if (sb_q[bus.out_ch].size() == 0) check("extra_beat", 64'(cur), 64'h0);
      else check("beat", 64'(cur), 64'(sb_q[bus.out_ch].pop_front()));
      if (mon_lock) check("lock_ch", 64'(bus.out_ch), 64'(mon_lock_ch));
      mon_lock    = (bus.out_cycle_type == CtValid);
      mon_lock_ch = bus.out_ch;
    end else begin
      stall_q    = 1'b1;
      stall_beat = cur;
      stall_ch   = bus.out_ch;
    end
  endtask

  // One clock: monitor on the falling edge, inputs released just after the rise
  task automatic cyc();
    @(negedge clk);
    if (rst_n) mon();
    @(posedge clk);
    #1;
    bus.in_clk_en     = '0;
    bus.in_cycle_type = '0;
    bus.in_wdat       = '0;
    bus.err_clr       = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    for (int i = 0; i < 300 && !sb_all_empty(); i++) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
    end
    check("drain_done", 64'(sb_all_empty()), 64'h1);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    logic [3:0]  in_txn;
    logic [63:0] r64;
    logic [1:0]  t;

    bus.in_clk_en     = '0;
    bus.in_cycle_type = '0;
    bus.in_wdat       = '0;
    bus.out_ready     = 1'b0;
    bus.err_clr       = 1'b0;

    // Reset values
    #2;
    check_out("rst_out", CtIdle, 36'h0, 2'd0);
    check("rst_ovf", 64'(bus.ovf), 64'h0);
    check("rst_proto", 64'(bus.proto_err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Single channel: beats appear one cycle after each push
    drive(2, CtValid, 36'hA, 1'b1); cyc();
    check_out("single_a", CtValid, 36'hA, 2'd2);
    drive(2, CtValid, 36'hB, 1'b1); cyc();
    check_out("single_b", CtValid, 36'hB, 2'd2);
    drive(2, CtDone, 36'hC, 1'b1); cyc();
    check_out("single_c", CtDone, 36'hC, 2'd2);
    cyc();
    check_out("single_idle", CtIdle, 36'h0, 2'd0);
    // Scan now starts at channel 3, so 3 beats 0
    drive(0, CtDone, 36'h10, 1'b1);
    drive(3, CtDone, 36'h13, 1'b1);
    cyc();
    check_out("rr_next3", CtDone, 36'h13, 2'd3);
    cyc();
    check_out("rr_then0", CtDone, 36'h10, 2'd0);
    cyc();

    // Transaction lock: channel 0 holds the bus across three bubbles
    drive(0, CtValid, 36'h20, 1'b1); cyc();
    check_out("lock_v", CtValid, 36'h20, 2'd0);
    drive(1, CtDone, 36'h31, 1'b1); cyc();
    for (int b = 0; b < 3; b++) begin
      check_out("lock_bubble", CtIdle, 36'h0, 2'd0);
      if (b == 2) drive(0, CtDone, 36'h22, 1'b1);
      cyc();
    end
    check_out("lock_done0", CtDone, 36'h22, 2'd0);
    cyc();
    check_out("lock_done1", CtDone, 36'h31, 2'd1);
    cyc();

    // Fairness: every channel streams lone DONEs, scan starts at channel 2
    for (int k = 0; k < 24; k++) begin
      if (k < 6) for (int c = 0; c < NUM_CH; c++) drive(c, CtDone, 36'((k << 4) | c), 1'b1);
      cyc();
      check("rr_ch", 64'(bus.out_ch), 64'((2 + k) % NUM_CH));
      check("rr_nobubble", 64'(bus.out_cycle_type), 64'(CtDone));
    end
    cyc();
    check_out("rr_idle", CtIdle, 36'h0, 2'd0);

    // Overflow: nine pushes into an 8-deep FIFO with the consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(3, CtValid, 36'(32'h40 + i), i < 8);
      cyc();
      check("ovf_flag", 64'(bus.ovf), (i == 8) ? 64'h8 : 64'h0);
    end
    check_out("ovf_head", CtValid, 36'h40, 2'd3);
    bus.err_clr = 1'b1; cyc();
    check("ovf_clr", 64'(bus.ovf), 64'h0);
    bus.out_ready = 1'b1;
    drive(3, CtValid, 36'h50, 1'b1); cyc();
    check("ovf_fullpop", 64'(bus.ovf), 64'h0);
    drive(3, CtDone, 36'h51, 1'b1); cyc();
    check("ovf_fullpop2", 64'(bus.ovf), 64'h0);
    drain(1'b0);
    check_out("ovf_drained", CtIdle, 36'h0, 2'd0);

    // Backpressure: random traffic and random ready, scoreboard checks order
    in_txn = '0;
    for (int n = 0; n < 80; n++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 3) == 0 && sb_q[c].size() < DEPTH - 2) begin
          t = ($urandom_range(0, 2) == 0) ? CtDone : CtValid;
          r64 = {$urandom(), $urandom()};
          drive(c, t, r64[35:0], 1'b1);
          in_txn[c] = (t == CtValid);
        end
      end
      cyc();
    end
    for (int c = 0; c < NUM_CH; c++) if (in_txn[c]) drive(c, CtDone, 36'(c), 1'b1);
    cyc();
    drain(1'b1);
    cyc();
    check_out("bp_idle", CtIdle, 36'h0, 2'd0);
    check("bp_no_ovf", 64'(bus.ovf), 64'h0);

    // Protocol error: type 3 is flagged and never enqueued
    drive(1, CtBad, 36'h99, 1'b0); cyc();
    check("proto_set", 64'(bus.proto_err), 64'h2);
    check_out("proto_noenq", CtIdle, 36'h0, 2'd0);
    bus.err_clr = 1'b1; cyc();
    check("proto_clr", 64'(bus.proto_err), 64'h0);
    drive(1, CtBad, 36'h98, 1'b0);
    bus.err_clr = 1'b1; cyc();
    check("proto_setwins", 64'(bus.proto_err), 64'h2);
    bus.err_clr = 1'b1; cyc();
    check("proto_clr2", 64'(bus.proto_err), 64'h0);

    // Reset mid-transaction discards everything, outputs drop immediately
    drive(2, CtValid, 36'h70, 1'b1); cyc();
    drive(2, CtValid, 36'h71, 1'b1); cyc();
    check_out("rst_lockhead", CtValid, 36'h71, 2'd2);
    bus.out_ready = 1'b0;
    drive(0, CtDone, 36'h72, 1'b1); cyc();
    rst_n = 1'b0;
    #1;
    check_out("rst_async_out", CtIdle, 36'h0, 2'd0);
    for (int c = 0; c < NUM_CH; c++) sb_q[c].delete();
    stall_q  = 1'b0;
    mon_lock = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("rst_empty", CtIdle, 36'h0, 2'd0);
    bus.out_ready = 1'b1;
    drive(0, CtDone, 36'h80, 1'b1); cyc();
    check_out("rst_fresh", CtDone, 36'h80, 2'd0);
    drain(1'b0);
    check_out("rst_final_idle", CtIdle, 36'h0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
